// File: rtl/memory_arbiter_if.sv
// Cache-pair and RAM bus seen by memory_arbiter. The slave modport is the arbiter,
// the master modport is whatever drives the caches and models the RAM.
interface memory_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    // Handshake: a cache holds its REN/WEN, addr and store stable until its wait
    // goes low; wait low marks the single completion cycle, load valid in it.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// Serialises icache reads and dcache reads/writes onto a single-port RAM, with a
// starvation guard so a dcache burst cannot lock the icache out indefinitely.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    memory_arbiter_if.slave   bus,
    output logic [7:0]        err_count,
    output logic [1:0]        state
);
    // state encoding is visible on the state port: 0 ARB, 1 DSERV, 2 ISERV
    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] DSERV = 2'd1;
    localparam logic [1:0] ISERV = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;

    localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    logic [1:0]    next_state;
    logic [SW-1:0] dstreak;
    logic          dreq;
    logic          ram_access;
    logic          streak_full;

    assign dreq        = bus.dREN | bus.dWEN;
    assign ram_access  = (bus.ramstate == RAM_ACCESS);
    assign streak_full = (dstreak == SW'(STARVE_LIMIT));

    always_comb begin
        next_state = state;
        case (state)
            ARB: begin
                if (dreq && !(bus.iREN && streak_full))
                    next_state = DSERV;
                else if (bus.iREN)
                    next_state = ISERV;
            end
            DSERV:   if (!dreq || ram_access) next_state = ARB;
            ISERV:   if (!bus.iREN || ram_access) next_state = ARB;
            default: next_state = ARB;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ARB;
            dstreak   <= '0;
            err_count <= '0;
        end else begin
            state <= next_state;
            if (state == ARB) begin
                if (!bus.iREN || next_state == ISERV)
                    dstreak <= '0;
                else if (next_state == DSERV && !streak_full)
                    dstreak <= dstreak + 1'b1;
            end
            if (state != ARB && bus.ramstate == RAM_ERROR && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    // RAM side is purely combinational from state so async reset drops strobes at once
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state)
            DSERV: begin
                bus.ramaddr  = bus.daddr;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramstore = bus.dWEN ? bus.dstore : 32'd0;
            end
            ISERV: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.dwait = !(state == DSERV && dreq && ram_access);
    assign bus.iwait = !(state == ISERV && bus.iREN && ram_access);
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// single-requester traffic checked against a transaction-level model.
module tb_memory_arbiter;
  localparam int LIMIT = 2;
  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;
  localparam logic [1:0] ST_ARB = 2'd0;

  logic       CLK;
  logic       nRST;
  logic [7:0] err_count;
  logic [1:0] state;
  int checks;
  int errors;
  int exp_err;
  logic [31:0] exp_q[$];

  memory_arbiter_if bus();

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .err_count(err_count), .state(state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // drive just after the rising edge, check mid-cycle
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0;
    bus.ramstate = FREE;
  endtask

  function automatic logic [1:0] non_access();
    logic [1:0] s;
    case ($urandom_range(0, 2))
      0: s = FREE;
      1: s = BUSY;
      default: s = ERROR;
    endcase
    return s;
  endfunction

  task automatic test_reset();
    idle_inputs();
    nRST = 0;
    bus.dREN = 1; bus.daddr = $urandom(); bus.iREN = 1; bus.iaddr = $urandom();
    bus.ramload = $urandom();
    #12;
    checks++;
    if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
      errors++; $display("FAIL reset_waits got i=%b d=%b exp 1 1", bus.iwait, bus.dwait);
    end
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'd0 || bus.ramstore !== 32'd0) begin
      errors++; $display("FAIL reset_ram got ren=%b wen=%b addr=%h store=%h exp 0", bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
    end
    checks++;
    if (err_count !== 8'd0 || state !== ST_ARB) begin
      errors++; $display("FAIL reset_regs got err=%0d state=%0d exp 0 0", err_count, state);
    end
    bus.ramload = $urandom();
    #1;
    checks++;
    if (bus.iload !== bus.ramload || bus.dload !== bus.ramload) begin
      errors++; $display("FAIL reset_load got i=%h d=%h exp %h", bus.iload, bus.dload, bus.ramload);
    end
    idle_inputs();
    tick();
    nRST = 1;
    exp_err = 0;
  endtask

  task automatic test_data_read();
    tick();
    bus.dREN = 1; bus.daddr = 32'h40; bus.ramstate = FREE;
    settle();
    checks++;
    if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1) begin
      errors++; $display("FAIL read_c0 got ren=%b dwait=%b exp 0 1", bus.ramREN, bus.dwait);
    end
    for (int c = 1; c <= 2; c++) begin
      tick(); bus.ramstate = BUSY; settle();
      checks++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40 || bus.dwait !== 1'b1) begin
        errors++; $display("FAIL read_busy%0d got ren=%b addr=%h dwait=%b exp 1 40 1", c, bus.ramREN, bus.ramaddr, bus.dwait);
      end
    end
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF; settle();
    checks++;
    if (bus.dwait !== 1'b0 || bus.dload !== 32'hDEADBEEF || bus.iwait !== 1'b1) begin
      errors++; $display("FAIL read_done got dwait=%b dload=%h iwait=%b exp 0 deadbeef 1", bus.dwait, bus.dload, bus.iwait);
    end
    tick(); idle_inputs(); settle();
    checks++;
    if (state !== ST_ARB || bus.ramREN !== 1'b0) begin
      errors++; $display("FAIL read_arb got state=%0d ren=%b exp 0 0", state, bus.ramREN);
    end
  endtask

  task automatic test_write_priority();
    tick();
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h3100; bus.dstore = 32'h5;
    for (int c = 1; c <= 3; c++) begin
      tick(); bus.ramstate = (c == 3) ? ACCESS : BUSY; settle();
      checks++;
      if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramstore !== 32'h5 || bus.ramaddr !== 32'h3100) begin
        errors++; $display("FAIL write_c%0d got wen=%b ren=%b store=%h addr=%h exp 1 0 5 3100", c, bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr);
      end
      checks++;
      if (bus.dwait !== (c != 3)) begin
        errors++; $display("FAIL write_dwait%0d got %b exp %b", c, bus.dwait, (c != 3));
      end
    end
    tick(); idle_inputs();
  endtask

  task automatic test_error_path();
    logic [31:0] a;
    a = $urandom();
    tick(); bus.iREN = 1; bus.iaddr = a; bus.ramstate = FREE;
    for (int c = 1; c <= 4; c++) begin
      tick(); bus.ramstate = (c == 4) ? ACCESS : ERROR; settle();
      checks++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== a || bus.iwait !== (c != 4) || bus.dwait !== 1'b1) begin
        errors++; $display("FAIL err_c%0d got ren=%b addr=%h iwait=%b dwait=%b exp 1 %h %b 1", c, bus.ramREN, bus.ramaddr, bus.iwait, bus.dwait, a, (c != 4));
      end
    end
    tick(); idle_inputs(); settle();
    exp_err = 3;
    checks++;
    if (err_count !== 8'd3) begin
      errors++; $display("FAIL err_count got %0d exp 3", err_count);
    end
  endtask

  task automatic test_request_drop();
    tick(); bus.dREN = 1; bus.daddr = $urandom();
    tick(); bus.ramstate = BUSY; settle();
    checks++;
    if (bus.ramREN !== 1'b1) begin
      errors++; $display("FAIL drop_busy got ren=%b exp 1", bus.ramREN);
    end
    tick(); bus.dREN = 0; settle();
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.dwait !== 1'b1) begin
      errors++; $display("FAIL drop_now got ren=%b wen=%b dwait=%b exp 0 0 1", bus.ramREN, bus.ramWEN, bus.dwait);
    end
    tick(); bus.dREN = 1; bus.ramstate = ACCESS; settle();
    checks++;
    if (state !== ST_ARB || bus.ramREN !== 1'b0 || bus.dwait !== 1'b1) begin
      errors++; $display("FAIL drop_arb got state=%0d ren=%b dwait=%b exp 0 0 1", state, bus.ramREN, bus.dwait);
    end
    bus.dREN = 0;
    tick(); idle_inputs();
  endtask

  task automatic test_simultaneous();
    string got;
    string want;
    int n;
    got = ""; want = ""; n = 0;
    tick(); idle_inputs();
    tick(); bus.iREN = 1; bus.dREN = 1; bus.ramstate = ACCESS;
    for (int c = 0; c < 24 && n < 6; c++) begin
      settle();
      checks++;
      if (bus.iwait === 1'b0 && bus.dwait === 1'b0) begin
        errors++; $display("FAIL sim_both_low cycle %0d got 0 0 exp not both", c);
      end
      if (bus.dwait === 1'b0) begin got = {got, "D"}; n++; end
      if (bus.iwait === 1'b0) begin got = {got, "I"}; n++; end
      tick();
    end
    // every (LIMIT+1)-th grant under sustained contention goes to the icache
    for (int k = 0; k < 6; k++) want = {want, ((k % (LIMIT + 1)) == LIMIT) ? "I" : "D"};
    checks++;
    if (got != want) begin
      errors++; $display("FAIL sim_order got %s exp %s", got, want);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic is_d, is_wr;
      logic [31:0] a, wd, rd, exp_ld;
      int lat;
      logic [1:0] rs;
      is_d = $urandom_range(0, 1); is_wr = is_d && $urandom_range(0, 1);
      a = $urandom(); wd = $urandom(); lat = $urandom_range(0, 3);
      tick();
      idle_inputs();
      if (is_d) begin bus.dREN = $urandom_range(0, 1) | ~is_wr; bus.dWEN = is_wr; bus.daddr = a; bus.dstore = wd; end
      else begin bus.iREN = 1; bus.iaddr = a; end
      bus.ramstate = non_access();
      settle();
      checks++;
      if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_arb got ren=%b wen=%b iw=%b dw=%b exp 0 0 1 1", t, bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait);
      end
      for (int k = 0; k <= lat; k++) begin
        tick();
        rs = (k == lat) ? ACCESS : non_access();
        bus.ramstate = rs;
        if (rs == ACCESS) begin
          rd = $urandom(); bus.ramload = rd; exp_q.push_back(rd);
        end else if (rs == ERROR && exp_err < 255) exp_err++;
        settle();
        checks++;
        if (bus.ramaddr !== a || bus.ramWEN !== is_wr || bus.ramREN !== !is_wr || bus.ramstore !== (is_wr ? wd : 32'd0)) begin
          errors++; $display("FAIL rnd%0d_ram got addr=%h wen=%b ren=%b store=%h exp %h %b %b %h", t, bus.ramaddr, bus.ramWEN, bus.ramREN, bus.ramstore, a, is_wr, !is_wr, is_wr ? wd : 32'd0);
        end
        checks++;
        if (bus.dwait !== !(is_d && rs == ACCESS) || bus.iwait !== !(!is_d && rs == ACCESS)) begin
          errors++; $display("FAIL rnd%0d_wait got iw=%b dw=%b exp %b %b", t, bus.iwait, bus.dwait, !(!is_d && rs == ACCESS), !(is_d && rs == ACCESS));
        end
        if (rs == ACCESS) begin
          exp_ld = exp_q.pop_front();
          checks++;
          if ((is_d ? bus.dload : bus.iload) !== exp_ld) begin
            errors++; $display("FAIL rnd%0d_load got %h exp %h", t, is_d ? bus.dload : bus.iload, exp_ld);
          end
        end
      end
    end
    tick(); idle_inputs(); settle();
    checks++;
    if (err_count !== exp_err[7:0]) begin
      errors++; $display("FAIL rnd_err_count got %0d exp %0d", err_count, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    tick(); bus.dWEN = 1; bus.daddr = $urandom(); bus.dstore = $urandom();
    tick(); bus.ramstate = BUSY; settle();
    checks++;
    if (bus.ramWEN !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got wen=%b exp 1", bus.ramWEN);
    end
    nRST = 0;
    #1;
    checks++;
    if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0 || bus.dwait !== 1'b1 || err_count !== 8'd0) begin
      errors++; $display("FAIL rstmid_now got wen=%b ren=%b dwait=%b err=%0d exp 0 0 1 0", bus.ramWEN, bus.ramREN, bus.dwait, err_count);
    end
    bus.ramstate = ACCESS;
    tick(); idle_inputs();
    #3 nRST = 1;
    tick(); settle();
    checks++;
    if (state !== ST_ARB || bus.ramWEN !== 1'b0 || bus.dwait !== 1'b1) begin
      errors++; $display("FAIL rstmid_after got state=%0d wen=%b dwait=%b exp 0 0 1", state, bus.ramWEN, bus.dwait);
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_err = 0;
    nRST = 0;
    bus.ramload = 0;
    idle_inputs();
    test_reset();
    test_data_read();
    test_write_priority();
    test_error_path();
    test_request_drop();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-core memory arbiter and responder for the cache control bus. Accepts word requests from the icache (read only) and the dcache (read/write). Serialises them onto the single-port RAM and returns per-requester `iwait`/`dwait` handshakes plus load data. Sits between the cache pair and the RAM model; it is the responder for every `dREN`/`dWEN`/`iREN` transaction the caches issue.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive dcache grants while `iREN` is pending before icache is forced.
- `CLK`  in  1  clock; rising-edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request; wins over `dREN` if both high.
- `daddr`  in  32  dcache word address.
- `dstore`  in  32  dcache write data.
- `iwait`  out  1  0 = icache access completes this cycle.
- `dwait`  out  1  0 = dcache access completes this cycle.
- `iload`  out  32  icache read data, valid when `iwait`=0.
- `dload`  out  32  dcache read data, valid when `dwait`=0.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
- `err_count`  out  8  saturating count of cycles the RAM reported ERROR.

## Operation
- FSM states: ARB, DSERV, ISERV. Reset state is ARB.
- ARB:
  - Drives no RAM strobes; `ramaddr` and `ramstore` = 0.
  - Arbitrates on the registered transition.
  - dcache request (`dREN|dWEN`) and no `iREN` -> DSERV.
  - `iREN` only -> ISERV.
  - Both present -> DSERV, unless `dstreak` == `STARVE_LIMIT`, in which case -> ISERV.
  - Neither -> stay in ARB.
- `dstreak` (3+ bits, saturating at `STARVE_LIMIT`):
  - +1 on each ARB->DSERV while `iREN`=1.
  - Cleared on ARB->ISERV, or on any ARB cycle with `iREN`=0.
- DSERV:
  - `ramaddr`=`daddr`.
  - `ramWEN`=`dWEN`; `ramREN`=`dREN & ~dWEN`.
  - `ramstore`=`dstore` when writing, else 0.
  - When `ramstate`=ACCESS: `dwait`=0 that cycle, next state ARB.
  - FREE/BUSY/ERROR: hold in DSERV.
  - `dREN`=`dWEN`=0: strobes drop combinationally, next state ARB, no completion.
- ISERV:
  - `ramaddr`=`iaddr`, `ramREN`=1, `ramWEN`=0, `ramstore`=0.
  - When `ramstate`=ACCESS: `iwait`=0 that cycle, next state ARB.
  - FREE/BUSY/ERROR: hold in ISERV.
  - `iREN`=0: next state ARB.
  - A dcache request arriving during ISERV waits; no preemption.
- `iload` = `dload` = `ramload` combinationally, at all times.
- `iwait` and `dwait` are 1 in every cycle except the single completion cycle of the granted side. Both are never 0 in the same cycle.
- `err_count` increments on each DSERV/ISERV cycle where `ramstate`=ERROR; it saturates at 255.
- ERROR is non-terminal: the access keeps being presented until ACCESS arrives or the requester drops its request.
- Mid-transaction address or data changes by the requester are passed straight through. Caches must hold `addr`/`store` stable until their wait goes low.

## Timing
- Reset (async):
  - State ARB, `dstreak`=0, `err_count`=0.
  - Outputs: `iwait`=`dwait`=1, `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0.
  - `iload`/`dload` follow `ramload`.
- Reset asserted mid-transaction: strobes drop immediately (asynchronously); the in-flight access is abandoned with no completion signalled.
- Latency: request seen in ARB at cycle 0; RAM strobe at cycle 1; completion in the first cycle k≥1 with `ramstate`=ACCESS. With a RAM that returns ACCESS on the first strobe cycle, each word takes 2 cycles.
- Back-to-back dcache beats (block fill, writeback): each beat pays one ARB bubble cycle. `iREN` may win that bubble only under the starvation rule.
- Completion and new requests are never accepted in the same cycle; arbitration is always registered.

## Test plan
- Data read: `dREN`=1, `daddr`=0x40; RAM gives BUSY×2 then ACCESS with `ramload`=0xDEADBEEF. Required: `ramREN`=1 from cycle 1; `dwait`=0 only in cycle 3 with `dload`=0xDEADBEEF; back in ARB at cycle 4.
- Write priority: `dREN`=`dWEN`=1, `daddr`=0x3100, `dstore`=0x5. Required: `ramWEN`=1, `ramREN`=0, `ramstore`=0x5, `ramaddr`=0x3100 until ACCESS.
- Simultaneous requests: `iREN` and `dREN` held high, RAM ACCESS immediately, `STARVE_LIMIT`=2. Required grant order: D, D, I, D, D, I; `iwait`/`dwait` never both 0 in one cycle.
- Error path: in ISERV, RAM returns ERROR×3 then ACCESS. Required: `err_count`=3, `iwait` low only on the ACCESS cycle, `ramREN` held throughout.
- Request drop: dcache drops `dREN` while BUSY. Required: strobes 0 in that same cycle; ARB next cycle; `dwait` stays 1.
- Reset mid-DSERV: pull `nRST` low between clock edges. Required: `ramWEN`/`ramREN`=0 and `dwait`=1 immediately; `err_count`=0; ARB after release.
